// File: rtl/vga_timing_pkg.sv
// Shared state type and default 640x480@60 timing constants
// for the parametrised VGA timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } vga_state_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int vga_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-strobe enabled shift register that delays the sync/blank word
// by DEPTH steps; DEPTH=0 is a plain wire.
module vga_sync_delay #(
    parameter int             DEPTH   = 0,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_ni, en_i};
        assign q_o = d_i;
    end else begin : g_dly
        logic [W-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel strobe, start/stop FSM, sync delay.
// Define VGA_TIMING_BORDER_EN to add the Border alignment output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10,
    parameter int SYNC_DLY = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Pix_En,
    input  logic             Enable,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             Frame_Start,
    output logic             Line_Start,
`ifdef VGA_TIMING_BORDER_EN
    output logic             Border,
`endif
    output logic             Running
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);

`ifdef VGA_TIMING_BORDER_EN
    localparam int SW = 4;
    localparam logic [CNT_W-1:0] H_EDGE = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_EDGE = CNT_W'(V_ACTIVE - 1);
`else
    localparam int SW = 3;
`endif

    // Word layout: [0]=HS, [1]=VS, [2]=BLANK_N, [3]=Border.
    localparam logic [SW-1:0] SYNC_RST = SW'({1'b0, ~VS_POL, ~HS_POL});

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    if (SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_bad_dly
        $error("vga_timing_gen: SYNC_DLY must be 0..4");
    end

    vga_state_t       state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [SW-1:0]    sync_q, sync_d, sync_dly;
    logic             fs_q, fs_d;
    logic             ls_q, ls_d;
    logic             active;
    logic             last_px;

    assign last_px = (h_q == H_LAST) && (v_q == V_LAST);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else if (Pix_En) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Enable) state_d = RUN;
            RUN:     if (!Enable) state_d = DRAIN;
            DRAIN: begin
                if (Enable) begin
                    state_d = RUN;
                end else if (last_px) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode from the next count so outputs register in step with it.
    always_comb begin
        h_d    = '0;
        v_d    = '0;
        active = (state_d != IDLE);
        if (active && state_q != IDLE) begin
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                v_d = v_q;
            end
        end
        sync_d    = SYNC_RST;
        sync_d[0] = (active && h_d >= HS_BEG && h_d < HS_END) ? HS_POL : ~HS_POL;
        sync_d[1] = (active && v_d >= VS_BEG && v_d < VS_END) ? VS_POL : ~VS_POL;
        sync_d[2] = active && (h_d < H_VIS) && (v_d < V_VIS);
`ifdef VGA_TIMING_BORDER_EN
        sync_d[3] = sync_d[2] && (h_d == '0 || h_d == H_EDGE ||
                                  v_d == '0 || v_d == V_EDGE);
`endif
        fs_d = active && (h_d == '0) && (v_d == '0);
        ls_d = active && (h_d == '0);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            h_q    <= '0;
            v_q    <= '0;
            sync_q <= SYNC_RST;
            fs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            fs_q <= Pix_En & fs_d;
            ls_q <= Pix_En & ls_d;
            if (Pix_En) begin
                h_q    <= h_d;
                v_q    <= v_d;
                sync_q <= sync_d;
            end
        end
    end

    vga_sync_delay #(
        .DEPTH   (SYNC_DLY),
        .W       (SW),
        .RST_VAL (SYNC_RST)
    ) u_sync_delay (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .en_i   (Pix_En),
        .d_i    (sync_q),
        .q_o    (sync_dly)
    );

    assign VGA_HS      = sync_dly[0];
    assign VGA_VS      = sync_dly[1];
    assign VGA_BLANK_N = sync_dly[2];
`ifdef VGA_TIMING_BORDER_EN
    assign Border      = sync_dly[3];
`endif
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign Frame_Start = fs_q;
    assign Line_Start  = ls_q;
    assign Running     = (state_q != IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny
// 8x6 instance with HS_POL=1 and SYNC_DLY=2, both against a frame model.
module tb_vga_timing_gen;

    localparam int HA_C [2] = '{640, 4};
    localparam int HF_C [2] = '{16, 1};
    localparam int HS_C [2] = '{96, 2};
    localparam int HB_C [2] = '{48, 1};
    localparam int VA_C [2] = '{480, 3};
    localparam int VF_C [2] = '{10, 1};
    localparam int VS_C [2] = '{2, 1};
    localparam int VB_C [2] = '{33, 1};
    localparam bit HP_C [2] = '{1'b0, 1'b1};
    localparam bit VP_C [2] = '{1'b0, 1'b0};
    localparam int DL_C [2] = '{0, 2};

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic Pix_En = 1'b0;
    logic Enable = 1'b0;

    logic [9:0] a_x, a_y;
    logic [3:0] b_x, b_y;
    logic a_hs, a_vs, a_bl, a_sn, a_fs, a_ls, a_run, a_bd;
    logic b_hs, b_vs, b_bl, b_sn, b_fs, b_ls, b_run, b_bd;

    int nasserts = 0;
    int nfail = 0;
    int cyc = 0;

    always #5 Clk = ~Clk;

    vga_timing_gen u_a (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Pix_En      (Pix_En),
        .Enable      (Enable),
        .VGA_HS      (a_hs),
        .VGA_VS      (a_vs),
        .VGA_BLANK_N (a_bl),
        .VGA_SYNC_N  (a_sn),
        .DrawX       (a_x),
        .DrawY       (a_y),
        .Frame_Start (a_fs),
        .Line_Start  (a_ls),
`ifdef VGA_TIMING_BORDER_EN
        .Border      (a_bd),
`endif
        .Running     (a_run)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b0),
        .CNT_W (4), .SYNC_DLY (2)
    ) u_b (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Pix_En      (Pix_En),
        .Enable      (Enable),
        .VGA_HS      (b_hs),
        .VGA_VS      (b_vs),
        .VGA_BLANK_N (b_bl),
        .VGA_SYNC_N  (b_sn),
        .DrawX       (b_x),
        .DrawY       (b_y),
        .Frame_Start (b_fs),
        .Line_Start  (b_ls),
`ifdef VGA_TIMING_BORDER_EN
        .Border      (b_bd),
`endif
        .Running     (b_run)
    );

`ifndef VGA_TIMING_BORDER_EN
    assign a_bd = 1'b0;
    assign b_bd = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nasserts++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: linear pixel index within the frame plus run/drain flags.
    int   p_m [2];
    bit   run_m [2];
    bit   drn_m [2];
    bit   fs_m [2];
    bit   ls_m [2];
    logic [3:0] hist [2][5];

    function automatic int ht(input int k);
        return HA_C[k] + HF_C[k] + HS_C[k] + HB_C[k];
    endfunction

    function automatic int tot(input int k);
        return ht(k) * (VA_C[k] + VF_C[k] + VS_C[k] + VB_C[k]);
    endfunction

    function automatic logic [3:0] rst_word(input int k);
        return {1'b0, 1'b0, ~VP_C[k], ~HP_C[k]};
    endfunction

    function automatic logic [3:0] word(input int k, input int p);
        int x, y;
        logic h, v, b, bd;
        x  = p % ht(k);
        y  = p / ht(k);
        h  = (x >= HA_C[k] + HF_C[k] && x < HA_C[k] + HF_C[k] + HS_C[k]) ? HP_C[k] : ~HP_C[k];
        v  = (y >= VA_C[k] + VF_C[k] && y < VA_C[k] + VF_C[k] + VS_C[k]) ? VP_C[k] : ~VP_C[k];
        b  = (x < HA_C[k]) && (y < VA_C[k]);
        bd = b && (x == 0 || x == HA_C[k] - 1 || y == 0 || y == VA_C[k] - 1);
        return {bd, b, v, h};
    endfunction

    task automatic model_step(input int k);
        if (!Reset_n) begin
            run_m[k] = 0;
            drn_m[k] = 0;
            p_m[k]   = 0;
            fs_m[k]  = 0;
            ls_m[k]  = 0;
            for (int d = 0; d < 5; d++) hist[k][d] = rst_word(k);
        end else begin
            fs_m[k] = 0;
            ls_m[k] = 0;
            if (Pix_En) begin
                if (!run_m[k]) begin
                    if (Enable) begin
                        run_m[k] = 1;
                        drn_m[k] = 0;
                        p_m[k]   = 0;
                        fs_m[k]  = 1;
                        ls_m[k]  = 1;
                    end
                end else if (drn_m[k] && !Enable && p_m[k] == tot(k) - 1) begin
                    run_m[k] = 0;
                    drn_m[k] = 0;
                    p_m[k]   = 0;
                end else begin
                    p_m[k]   = (p_m[k] + 1) % tot(k);
                    drn_m[k] = !Enable;
                    fs_m[k]  = (p_m[k] == 0);
                    ls_m[k]  = (p_m[k] % ht(k) == 0);
                end
                for (int d = 4; d > 0; d--) hist[k][d] = hist[k][d-1];
                hist[k][0] = run_m[k] ? word(k, p_m[k]) : rst_word(k);
            end
        end
    endtask

    always @(posedge Clk) begin
        model_step(0);
        model_step(1);
        cyc++;
    end

    task automatic cmp(input int k, input int x, input int y,
                       input logic hs, input logic vs, input logic bl,
                       input logic sn, input logic fs, input logic ls,
                       input logic rn, input logic bd);
        logic [3:0] w;
        string n;
        w = hist[k][DL_C[k]];
        n = (k == 0) ? "A" : "B";
        chk($sformatf("%s.DrawX", n), x, p_m[k] % ht(k));
        chk($sformatf("%s.DrawY", n), y, p_m[k] / ht(k));
        chk($sformatf("%s.HS", n), hs, w[0]);
        chk($sformatf("%s.VS", n), vs, w[1]);
        chk($sformatf("%s.BLANK_N", n), bl, w[2]);
        chk($sformatf("%s.SYNC_N", n), sn, 0);
        chk($sformatf("%s.Frame_Start", n), fs, fs_m[k]);
        chk($sformatf("%s.Line_Start", n), ls, ls_m[k]);
        chk($sformatf("%s.Running", n), rn, run_m[k]);
`ifdef VGA_TIMING_BORDER_EN
        chk($sformatf("%s.Border", n), bd, w[3]);
`else
        if (bd !== 1'b0) chk($sformatf("%s.Border_tie", n), bd, 0);
`endif
    endtask

    always @(negedge Clk) begin
        cmp(0, a_x, a_y, a_hs, a_vs, a_bl, a_sn, a_fs, a_ls, a_run, a_bd);
        cmp(1, b_x, b_y, b_hs, b_vs, b_bl, b_sn, b_fs, b_ls, b_run, b_bd);
    end

    // Hand-derived pins on the decode windows, independent of the model.
    always @(negedge Clk) begin
        if (a_run) begin
            if (a_x == 656 || a_x == 751) chk("A.hs_in_window", a_hs, 0);
            if (a_x == 655 || a_x == 752) chk("A.hs_outside", a_hs, 1);
            if (a_x == 639 && a_y < 480) chk("A.blank_last_vis", a_bl, 1);
            if (a_x == 640) chk("A.blank_first_porch", a_bl, 0);
        end
        if (b_run) begin
            if (b_x == 7) chk("B.hs_delayed_h5", b_hs, 1);
            if (b_x == 5) chk("B.hs_delayed_h3", b_hs, 0);
        end
    end

    bit per_on = 0;
    int last_ls_a = -1;
    int last_fs_b = -1;
    int fs_cnt_a = 0;

    always @(negedge Clk) begin
        if (per_on) begin
            if (a_fs) fs_cnt_a++;
            if (a_ls) begin
                if (last_ls_a >= 0) chk("A.line_period", cyc - last_ls_a, 1600);
                last_ls_a = cyc;
            end
            if (b_fs) begin
                if (last_fs_b >= 0) chk("B.frame_period", cyc - last_fs_b, 96);
                last_fs_b = cyc;
            end
        end
    end

    task automatic wait_b(input int x, input int y, input int lim);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (b_x == x && (y < 0 || b_y == y)) begin
                ok = 1;
                break;
            end
            @(negedge Clk);
        end
        chk("B.wait_pos", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, lx, ly, hold, lowrun;

        Reset_n = 0;
        Enable  = 0;
        Pix_En  = 1;
        repeat (3) @(negedge Clk);
        chk("rst.A.HS", a_hs, 1);
        chk("rst.A.VS", a_vs, 1);
        chk("rst.A.BLANK_N", a_bl, 0);
        chk("rst.A.DrawX", a_x, 0);
        chk("rst.A.DrawY", a_y, 0);
        chk("rst.A.Running", a_run, 0);
        chk("rst.B.HS", b_hs, 0);

        Reset_n = 1;
        repeat (20) begin
            @(negedge Clk);
            Pix_En = 1'($urandom_range(0, 1));
        end
        @(negedge Clk);
        chk("idle.A.Running", a_run, 0);
        chk("idle.A.DrawX", a_x, 0);
        chk("idle.A.HS", a_hs, 1);
        chk("idle.B.HS", b_hs, 0);

        // Pixel strobe on every second clock.
        Pix_En = 0;
        Enable = 1;
        per_on = 1;
        repeat (5000) begin
            @(negedge Clk);
            Pix_En = ~Pix_En;
        end
        per_on = 0;
        chk("A.frame_starts", fs_cnt_a, 1);

        // Stop mid-frame on B: it must finish the frame, then idle.
        Pix_En = 1;
        wait_b(2, 3, 200);
        Enable = 0;
        cnt = 0;
        lx = -1;
        ly = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (!b_run) break;
            cnt++;
            lx = b_x;
            ly = b_y;
        end
        chk("B.drain_steps", cnt, 21);
        chk("B.drain_last_x", lx, 7);
        chk("B.drain_last_y", ly, 5);
        chk("B.idle_x", b_x, 0);
        chk("B.idle_y", b_y, 0);

        // Re-raise Enable during drain: no restart, no extra frame pulse.
        Enable = 1;
        wait_b(2, 1, 200);
        Enable = 0;
        repeat (3) @(negedge Clk);
        Enable = 1;
        cnt = 0;
        lowrun = 0;
        repeat (20) begin
            @(negedge Clk);
            if (b_fs) cnt++;
            if (!b_run) lowrun++;
        end
        chk("B.redrain_fs", cnt, 0);
        chk("B.redrain_run", lowrun, 0);

        hold = 0;
        repeat (20000) begin
            @(negedge Clk);
            Pix_En = ($urandom_range(0, 3) != 0);
            if (hold == 0) begin
                Enable = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 150);
            end
            hold--;
        end

        // Reset mid-line while running, with B's delayed HS high.
        Enable = 1;
        Pix_En = 1;
        repeat (10) @(negedge Clk);
        wait_b(7, -1, 200);
        chk("pre_rst.B.HS", b_hs, 1);
        chk("pre_rst.A.Running", a_run, 1);
        Reset_n = 0;
        @(negedge Clk);
        chk("mid_rst.A.Running", a_run, 0);
        chk("mid_rst.A.DrawX", a_x, 0);
        chk("mid_rst.A.HS", a_hs, 1);
        chk("mid_rst.A.BLANK_N", a_bl, 0);
        chk("mid_rst.B.HS", b_hs, 0);
        chk("mid_rst.B.BLANK_N", b_bl, 0);
        chk("mid_rst.B.DrawX", b_x, 0);
        chk("mid_rst.B.Running", b_run, 0);
        Reset_n = 1;
        repeat (30) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end

endmodule
